// File: rtl/col_frame_packer.sv
// Column frame packer: buffers encoded column words in a FIFO and streams them
// out wrapped in a header/trailer frame over a valid/ready link.
module col_frame_packer #(
   parameter int          DEPTH   = 64,
   parameter logic [3:0]  HDR_TAG = 4'hA,
   parameter logic [3:0]  TRL_TAG = 4'hE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              encoded_value,
   input  logic                     val_ready,
   input  logic                     col_done,
   output logic [15:0]              out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] RSV_LVL  = (AW+1)'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   logic [16:0]  mem [DEPTH];
   logic [AW:0]  wptr, rptr, level;
   logic [11:0]  cnt, col_idx;
   logic         end_pending;
   state_t       state;

   logic         mark_now, push, word_ok, drop, pop, empty;
   logic [16:0]  din, head;

   assign level      = wptr - rptr;
   assign empty      = (level == '0);
   assign fifo_level = level;
   assign head       = mem[rptr[AW-1:0]];
   assign pop        = (state == PAY) && !empty && out_ready;

   // A pending marker owns the write slot; a word arriving alongside it is lost.
   assign mark_now = end_pending || (col_done && !val_ready);

   always_comb begin
      push    = 1'b0;
      word_ok = 1'b0;
      drop    = 1'b0;
      din     = '0;
      if (mark_now) begin
         if (level != FULL_LVL) begin
            push = 1'b1;
            din  = {1'b1, 4'h0, cnt};
         end else begin
            drop = 1'b1;
         end
         if (val_ready) drop = 1'b1;
      end else if (val_ready) begin
         // last slot stays free so the column's trailer can always land
         if (level < RSV_LVL) begin
            push    = 1'b1;
            word_ok = 1'b1;
            din     = {1'b0, encoded_value};
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr        <= '0;
         cnt         <= '0;
         end_pending <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wptr     <= wptr + (AW+1)'(push);
         overflow <= overflow | drop;
         if (mark_now)                     cnt <= '0;
         else if (word_ok && cnt != 12'hFFF) cnt <= cnt + 12'd1;
         if (end_pending) end_pending <= col_done;
         else             end_pending <= col_done && val_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rptr    <= '0;
         col_idx <= '0;
      end else begin
         rptr <= rptr + (AW+1)'(pop);
         case (state)
            IDLE: if (!empty) state <= HDR;
            HDR:  if (out_ready) state <= PAY;
            PAY:  if (pop && head[16]) begin
                     col_idx <= col_idx + 12'd1;
                     state   <= IDLE;
                  end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs derive only from registered state and the FIFO head, so they hold
   // until the handshake consumes them.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      case (state)
         HDR: begin
            out_valid = 1'b1;
            out_data  = {HDR_TAG, col_idx};
         end
         PAY: if (!empty) begin
            out_valid = 1'b1;
            out_data  = head[16] ? {TRL_TAG, head[11:0]} : head[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: doc/col_frame_packer.md
Name: col_frame_packer

Overview:
- Sits directly downstream of the column encoder.
- Captures each 16-bit encoded word strobed by val_ready and buffers it in an internal FIFO.
- Wraps each column's words in a header/trailer frame and streams them out over a valid/ready interface to the readout link.
- Decouples the 20 MHz pixel-rate encoder from a back-pressuring consumer; flags overflow.

Parameters:
DEPTH, 64, FIFO entries (power of 2, >=4); each entry is 17 bits: marker flag plus 16 data bits
HDR_TAG, 4'hA, upper nibble of header word
TRL_TAG, 4'hE, upper nibble of trailer word

Ports:
clk  input  1  system clock (20 MHz pixel clock domain)
rst_n  input  1  asynchronous active-low reset
encoded_value  input  16  encoded word from column encoder
val_ready  input  1  single-cycle strobe, encoded_value valid
col_done  input  1  single-cycle pulse from readout sequencer: current column finished
out_data  output  16  framed output word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts word when out_valid&&out_ready
overflow  output  1  sticky: a word or marker was dropped
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. Asserting rst_n low at any time, including mid-frame, immediately empties the FIFO and clears all state.
- Reset values: out_valid=0, out_data=0, overflow=0, fifo_level=0, word count=0, col_idx=0, FSM=IDLE, end_pending=0.
- Write side:
  - val_ready=1 pushes {1'b0, encoded_value} and increments word count. Count is 12 bits and saturates at 4095.
  - col_done=1 pushes marker {1'b1, 4'h0, count[11:0]} and resets count to 0 in the same cycle.
  - If val_ready and col_done occur in the same cycle, the word is pushed this cycle and end_pending is set. The marker is pushed next cycle, with a count that includes that word.
  - If col_done arrives while end_pending=1, the first marker is pushed and the second becomes pending. Markers are never merged.
- Full handling:
  - The last free FIFO slot is reserved for markers. A payload push is dropped when fifo_level >= DEPTH-1. A dropped payload sets overflow and does not increment count.
  - A marker is dropped only when fifo_level == DEPTH, which also sets overflow.
  - overflow is cleared only by reset.
- Read FSM: states are IDLE, HDR and PAY.
  - IDLE: out_valid=0. Go to HDR when fifo_level != 0.
  - HDR: out_valid=1, out_data={HDR_TAG, col_idx[11:0]}. On handshake, go to PAY. Nothing is popped.
  - PAY, head is a data entry: out_valid=1, out_data=head[15:0]. On handshake, pop.
  - PAY, head is a marker: out_valid=1, out_data={TRL_TAG, head[11:0]}. On handshake, pop, increment col_idx (12-bit, wraps 4095->0) and go to IDLE.
  - PAY, FIFO empty: out_valid=0 and the FSM stays in PAY.
- Output timing:
  - out_valid and out_data are driven combinationally from the registered FSM state and the registered FIFO head.
  - Once asserted, out_valid and out_data must hold stable until the handshake completes.
- Latency:
  - A word written at edge N is visible at the FIFO head after edge N.
  - With out_ready=1 and an idle FSM, the header appears on out_data in cycle N+1 and the first payload word in N+2.
- Simultaneous push and pop in the same cycle is allowed. fifo_level is unchanged, and a push into a full FIFO is still rejected.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the extra pointer bit.
- An empty column (col_done with count=0) produces exactly two words: header, then trailer with count 0.

Test Plan:
- Reset, then 3 val_ready strobes with 16'h1111, 16'h2222, 16'h3333, then col_done, with out_ready=1 -> out stream A000, 1111, 2222, 3333, E003; col_idx becomes 1; overflow=0.
- val_ready with 16'hBEEF in the same cycle as col_done -> stream A000, BEEF, E001. The marker appears in the FIFO one cycle after the word.
- col_done twice with no data -> A000, E000, A001, E000.
- out_ready=0, then 70 val_ready strobes plus col_done with DEPTH=64 -> fifo_level reaches 64 (63 words + marker); overflow=1. After releasing out_ready, stream is A000, 63 words, E03F.
- out_ready toggled 0/1 every cycle during a 5-word column -> each word is held stable while out_valid=1 and out_ready=0; no duplicates and no losses.
- rst_n pulsed low mid-frame (FSM in PAY, fifo_level=4) -> out_valid=0 and fifo_level=0 immediately, without waiting for a clock edge. The next column starts with header A000.
